// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared widths and control-bundle layout for the pipeline stage
// register and its helpers. Field offsets index bits of the packed control
// bundle carried alongside each payload beat.
package pipe_pkg;

    // Default payload, control and bubble-counter widths.
    localparam int DATA_W_DEF = 16;
    localparam int CTRL_W_DEF = 20;
    localparam int CNT_W_DEF  = 2;

    // Bit offset of each field inside the control bundle. Single-bit flags
    // occupy offsets 0..11; the ALU operation field starts at CF_ALU_SIGNALS
    // and runs to the top of the bundle.
    typedef enum logic [4:0] {
        CF_IR          = 5'd0,
        CF_IW          = 5'd1,
        CF_MR          = 5'd2,
        CF_MW          = 5'd3,
        CF_MTR         = 5'd4,
        CF_ALU_SRC     = 5'd5,
        CF_RW          = 5'd6,
        CF_BRANCH      = 5'd7,
        CF_SETC        = 5'd8,
        CF_CLRC        = 5'd9,
        CF_ST          = 5'd10,
        CF_SST         = 5'd11,
        CF_ALU_SIGNALS = 5'd12
    } ctrl_field_e;

    // Width of the ALU operation field in the default bundle.
    localparam int ALU_SIG_W = CTRL_W_DEF - int'(CF_ALU_SIGNALS);

    // A bubble must carry no side effects, so the control bundle is gated
    // to zero whenever the entry is not valid.
    function automatic logic [CTRL_W_DEF-1:0] gate_ctrl(
        input logic                  valid,
        input logic [CTRL_W_DEF-1:0] ctrl
    );
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/pipe_flush_ctr.sv
// pipe_flush_ctr -- bubble-window counter. Loads a window length on a flush,
// then counts down once per falling edge and saturates at zero. Reset wins
// over load.
module pipe_flush_ctr
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [CNT_W-1:0] LoadVal,
    output logic [CNT_W-1:0] Cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Reset clears, a flush (re)loads the window, otherwise count down to 0.
    always_ff @(negedge Clk) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (Load) begin
            r_cnt <= LoadVal;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign Cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline stage register with flush bubbles.
// All state changes on the falling edge of Clk; Rst is synchronous and
// active-high and overrides Flush, which in turn overrides accept/issue.
//
// Build option PIPE_STAGE_SKID_EN: when defined the stage holds a main and a
// skid entry so InReady can come straight from a flop (skid empty) while
// still sustaining one beat per cycle. When undefined the stage is a single
// entry whose InReady looks through to OutReady combinationally.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [CTRL_W-1:0] OutCtrl,
    input  logic              Flush,
    input  logic [CNT_W-1:0]  FlushLen,
    output logic [CNT_W-1:0]  FlushCnt
);

    logic [CNT_W-1:0] w_cnt;
    logic             w_bubble;   // bubble window running: swallow input
    logic             w_accept;
    logic             w_issue;

    // Main (output-facing) entry.
    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    pipe_flush_ctr #(
        .CNT_W (CNT_W)
    ) u_flush_ctr (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (Flush),
        .LoadVal (FlushLen),
        .Cnt     (w_cnt)
    );

    assign w_bubble = (w_cnt != '0);
    assign w_accept = InValid && InReady;
    assign w_issue  = r_vld && OutReady;

`ifdef PIPE_STAGE_SKID_EN

    // Skid entry: catches the beat accepted while the main entry is stalled.
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // Ready depends only on flops (skid empty) plus the reset/bubble gating,
    // so no combinational path runs from OutReady to InReady.
    assign InReady = !Rst && (w_bubble || !r_skid_vld);

    // Main/skid update: issue drains skid into main or refills from input;
    // a stalled main diverts a new beat into skid.
    always_ff @(negedge Clk) begin
        if (Rst || Flush || w_bubble) begin
            r_vld       <= 1'b0;
            r_data      <= '0;
            r_ctrl      <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (w_issue) begin
            if (r_skid_vld) begin
                // Skid full means InReady was low: no accept this edge.
                r_data     <= r_skid_data;
                r_ctrl     <= r_skid_ctrl;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_data <= InData;
                r_ctrl <= InCtrl;
            end else begin
                r_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_vld) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= InData;
                r_skid_ctrl <= InCtrl;
            end else begin
                r_vld  <= 1'b1;
                r_data <= InData;
                r_ctrl <= InCtrl;
            end
        end
    end

`else

    // Single entry: ready when empty or when the held beat leaves this edge.
    assign InReady = !Rst && (w_bubble || !r_vld || OutReady);

    // Single-entry update: accept (possibly replacing an issuing beat) or
    // empty out on a bare issue.
    always_ff @(negedge Clk) begin
        if (Rst || Flush || w_bubble) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ctrl <= '0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_data <= InData;
            r_ctrl <= InCtrl;
        end else if (w_issue) begin
            r_vld <= 1'b0;
        end
    end

`endif

    assign OutValid = r_vld;
    assign OutData  = r_data;
    assign OutCtrl  = r_vld ? r_ctrl : '0;
    assign FlushCnt = w_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- scoreboard bench. The driver keeps a behavioural model
// of the stage as a FIFO of held beats (capacity 1 with look-through ready,
// or capacity 2 with skid) plus an integer bubble counter, and pushes each
// beat the model keeps into a scoreboard queue. An independent monitor pops
// that queue whenever the DUT issues a beat.
module tb_pipe_stage_reg;

    localparam int DW = 16;
    localparam int CW = 20;
    localparam int NW = 2;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [DW-1:0] InData = '0;
    logic [CW-1:0] InCtrl = '0;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [DW-1:0] OutData;
    logic [CW-1:0] OutCtrl;
    logic          Flush = 1'b0;
    logic [NW-1:0] FlushLen = '0;
    logic [NW-1:0] FlushCnt;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .InCtrl   (InCtrl),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutCtrl  (OutCtrl),
        .Flush    (Flush),
        .FlushLen (FlushLen),
        .FlushCnt (FlushCnt)
    );

    beat_t mq[$];   // model: beats held in the stage, head = output
    beat_t sb[$];   // scoreboard: beats the monitor expects to see issued
    int    m_cnt   = 0;
    bit    m_known = 1'b0;
    bit    g_acc   = 1'b0;
    int    total   = 0;
    int    bad     = 0;
    beat_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at posedge, check model vs DUT before the falling
    // edge, then advance the model to what that edge should produce.
    task automatic cyc(input bit rst, input bit fl, input int flen, input bit iv,
                       input logic [DW-1:0] d, input logic [CW-1:0] c, input bit ordy);
        bit rdy_m;
        bit acc;
        bit iss;
        beat_t b;
        @(posedge Clk);
        Rst = rst; Flush = fl; FlushLen = NW'(flen);
        InValid = iv; InData = d; InCtrl = c; OutReady = ordy;
        #1;
        if (rst)                rdy_m = 1'b0;
        else if (m_cnt != 0)    rdy_m = 1'b1;
        else if (SKID)          rdy_m = (mq.size() < 2);
        else                    rdy_m = (mq.size() == 0) || ordy;
        chk("in_ready", 32'(InReady), 32'(rdy_m));
        if (m_known) begin
            chk("out_valid", 32'(OutValid), 32'(mq.size() > 0));
            chk("flush_cnt", 32'(FlushCnt), 32'(m_cnt));
            if (mq.size() > 0) begin
                chk("out_data_held", 32'(OutData), 32'(mq[0].d));
                chk("out_ctrl_held", 32'(OutCtrl), 32'(mq[0].c));
            end else begin
                chk("out_ctrl_bubble", 32'(OutCtrl), 32'd0);
            end
        end
        acc   = iv && rdy_m;
        iss   = (mq.size() > 0) && ordy;
        g_acc = acc;
        #1;
        b.d = d;
        b.c = c;
        if (rst) begin
            mq.delete(); sb.delete(); m_cnt = 0; m_known = 1'b1;
        end else if (fl) begin
            mq.delete(); sb.delete(); m_cnt = flen;
        end else if (m_cnt != 0) begin
            m_cnt--;
        end else begin
            if (iss) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(b);
                sb.push_back(b);
            end
        end
    endtask

    // Monitor: every DUT issue must match the oldest outstanding beat.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (m_known && !Rst && !Flush && OutValid === 1'b1 && OutReady) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL issue_unexpected: got %0h want no beat at %0t", OutData, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("issue_data", 32'(OutData), 32'(mon_e.d));
                    chk("issue_ctrl", 32'(OutCtrl), 32'(mon_e.c));
                end
            end
        end
    end

    initial begin
        bit done;
        bit rb;
        bit fb;

        // Reset held two cycles with live input.
        repeat (2) cyc(1, 0, 0, 1, 16'hFFFF, CW'(20'hFFFFF), 1);

        // Streaming 0..7 at full rate.
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, DW'(i), CW'($urandom), 1);
        repeat (2) cyc(0, 0, 0, 0, '0, '0, 1);

        // Backpressure: stall three cycles, then release.
        cyc(0, 0, 0, 1, 16'hA5A5, CW'(20'h12345), 0);
        done = 1'b0;
        repeat (2) begin
            cyc(0, 0, 0, !done, 16'h5A5A, CW'(20'h0ABCD), 0);
            done |= g_acc;
        end
        repeat (4) begin
            cyc(0, 0, 0, !done, 16'h5A5A, CW'(20'h0ABCD), 1);
            done |= g_acc;
        end

        // Flush while full, input kept valid through the window.
        cyc(0, 0, 0, 1, 16'h0100, CW'($urandom), 0);
        cyc(0, 0, 0, 1, 16'h0101, CW'($urandom), 0);
        cyc(0, 1, 2, 1, 16'h0200, CW'($urandom), 1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, DW'(16'h0201 + k), CW'($urandom), 1);
        cyc(0, 0, 0, 1, 16'h0210, CW'($urandom), 1);
        cyc(0, 0, 0, 1, 16'h0211, CW'($urandom), 1);
        repeat (2) cyc(0, 0, 0, 0, '0, '0, 1);

        // Priority: reset beats flush; flush reloads a running window.
        cyc(1, 1, 3, 1, 16'h0300, CW'($urandom), 1);
        cyc(0, 1, 2, 0, '0, '0, 1);
        cyc(0, 0, 0, 0, '0, '0, 1);
        cyc(0, 1, 3, 0, '0, '0, 1);
        repeat (4) cyc(0, 0, 0, 1, 16'h0333, CW'($urandom), 1);

        // FlushLen=0 clears the entry only; traffic resumes next cycle.
        cyc(0, 0, 0, 1, 16'h0400, CW'($urandom), 0);
        cyc(0, 1, 0, 1, 16'h0401, CW'($urandom), 1);
        cyc(0, 0, 0, 1, 16'h0402, CW'($urandom), 1);
        cyc(0, 0, 0, 0, '0, '0, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            rb = ($urandom_range(63) == 0);
            fb = ($urandom_range(15) == 0);
            cyc(rb, fb, int'($urandom_range(3)), $urandom_range(9) < 7,
                DW'($urandom), CW'($urandom), $urandom_range(9) < 7);
        end

        // Drain and confirm nothing is left outstanding.
        repeat (6) cyc(0, 0, 0, 0, '0, '0, 1);
        @(posedge Clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the operand/instruction payload.
REQ-002 SHALL have parameter CTRL_W, default 20, width of the packed control-signal bundle.
REQ-003 SHALL have parameter CNT_W, default 2, width of the flush-bubble counter.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 SHALL have the following ports:
- Clk  in  1  clock; all state updates on the falling edge.
- Rst  in  1  synchronous active-high reset.
- InValid  in  1  upstream beat present.
- InReady  out  1  stage can accept a beat.
- InData  in  DATA_W  upstream payload.
- InCtrl  in  CTRL_W  upstream control bundle.
- OutValid  out  1  downstream beat present.
- OutReady  in  1  downstream accepts the beat.
- OutData  out  DATA_W  held payload.
- OutCtrl  out  CTRL_W  held control; all-zero when OutValid=0.
- Flush  in  1  discard contents and start a bubble window.
- FlushLen  in  CNT_W  bubble-window length, in cycles.
- FlushCnt  out  CNT_W  remaining bubble cycles.

Function
REQ-006 SHALL transfer a beat on an edge when InValid&&InReady (accept) or OutValid&&OutReady (issue).
REQ-007 SHALL give 1-edge latency: a beat accepted into an empty stage drives OutValid=1 after the next falling edge.
REQ-008 SHALL hold OutData/OutCtrl stable while OutValid=1 and OutReady=0.
REQ-009 SHALL drive OutCtrl to zero whenever OutValid=0, so that bubbles carry no write/branch side effects.
REQ-010 SHALL, on accept and issue at the same edge, replace the output entry with the new beat without a bubble.
REQ-011 SHALL, on an edge with Flush=1, clear every held entry and load FlushCnt with FlushLen; Flush overrides a simultaneous accept or issue.
REQ-012 SHALL, while FlushCnt!=0, force InReady=1, discard accepted beats, keep OutValid=0, and decrement FlushCnt by 1 per edge (saturating at 0).
REQ-013 SHALL reload FlushCnt from FlushLen on a Flush during a running window; FlushLen=0 SHALL clear the entries only.
REQ-014 SHALL never duplicate, reorder or drop a beat except under REQ-011 and REQ-012.

Reset
REQ-015 SHALL, on an edge with Rst=1, clear all entries and FlushCnt, giving OutValid=0, OutData=0, OutCtrl=0 and FlushCnt=0; Rst overrides Flush.
REQ-016 SHALL drive InReady=0 while Rst=1, and SHALL assert it on the first cycle after Rst deasserts.
REQ-017 SHALL discard, without partial output, any beat in flight when Rst asserts mid-stream.

Configuration
REQ-018 SHALL, with PIPE_STAGE_SKID_EN defined, use a two-entry main+skid buffer:
- InReady is a registered signal, equal to skid-entry empty.
- A beat accepted while the main entry is stalled goes to the skid entry.
- The skid entry moves to main on the next issue.
- Sustained throughput is 1 beat per cycle.
REQ-019 SHALL, without PIPE_STAGE_SKID_EN, use a single entry with combinational InReady = !OutValid || OutReady (when FlushCnt=0 and Rst=0).

Structure
REQ-020 SHALL take default widths and a control-bundle field-offset enum (IR, IW, MR, MW, MTR, ALU_src, RW, Branch, SetC, CLRC, ST, SST, aluSignals) from shared package pipe_pkg.
REQ-021 SHALL implement the flush-bubble counter as sub-module pipe_flush_ctr, with ports Clk, Rst, Load, LoadVal, Cnt.

Verification
REQ-022 Reset: Rst=1 for 2 cycles with InValid=1 and InData=16'hFFFF -> OutValid=0, OutCtrl=0, FlushCnt=0 and InReady=0 throughout.
REQ-023 Streaming: 8 beats with InData=0..7 and OutReady=1 -> OutData=0..7 in order, one per cycle, first beat 1 edge after accept.
REQ-024 Backpressure: OutReady=0 for 3 cycles while sending 16'hA5A5 then 16'h5A5A ->
- OutData holds 16'hA5A5.
- Skid build: second beat held in skid, InReady=0.
- Non-skid build: InReady=0 after the first beat.
- Both builds: release yields 16'hA5A5 then 16'h5A5A.
REQ-025 Flush: Flush=1 with FlushLen=2 while full, InValid=1 continuous -> OutValid=0 for 3 edges, FlushCnt goes 2,1,0, dropped beats never appear, and the next beat issues normally.
REQ-026 Priority: Rst=1 and Flush=1 with FlushLen=3 on the same edge -> FlushCnt=0; then Flush during FlushCnt=1 with FlushLen=3 -> FlushCnt reloads to 3.
